// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler sharing the vga_adapter pixel port among sprite drawers; scans each job through a sync ROM.
// Optional colour-key transparency: define DRAW_SCHED_TRANSPARENCY_EN.
module sprite_draw_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int SZ_W = 5,
    parameter int ADDR_W = 12,
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*9-1:0]      req_x,
    input  logic [NUM_REQ*8-1:0]      req_y,
    input  logic [NUM_REQ*SZ_W-1:0]   req_w,
    input  logic [NUM_REQ*SZ_W-1:0]   req_h,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ-1:0]        req_blackout,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [2:0]                rom_data,
    output logic [8:0]                vga_x,
    output logic [7:0]                vga_y,
    output logic [2:0]                vga_colour,
    output logic                      vga_plot
);
    localparam int PTR_W = $clog2(NUM_REQ);
`ifdef DRAW_SCHED_TRANSPARENCY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
    state_t state_reg, state_next;

    logic [8:0]        x_arr    [NUM_REQ];
    logic [7:0]        y_arr    [NUM_REQ];
    logic [SZ_W-1:0]   w_arr    [NUM_REQ];
    logic [SZ_W-1:0]   h_arr    [NUM_REQ];
    logic [ADDR_W-1:0] base_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign x_arr[gi]    = req_x[9*gi +: 9];
            assign y_arr[gi]    = req_y[8*gi +: 8];
            assign w_arr[gi]    = req_w[SZ_W*gi +: SZ_W];
            assign h_arr[gi]    = req_h[SZ_W*gi +: SZ_W];
            assign base_arr[gi] = req_base[ADDR_W*gi +: ADDR_W];
        end
    endgenerate

    logic [PTR_W-1:0]  ptr_reg, owner_reg, sel_idx;
    logic [PTR_W:0]    cand;
    logic              sel_found, start, pix_valid, last_pix, show;
    logic [8:0]        x_reg;
    logic [7:0]        y_reg;
    logic [SZ_W-1:0]   w_reg, h_reg, col_reg, row_reg;
    logic              blackout_reg, busy_reg, p1_valid_reg, p1_clip_reg, plot_reg;
    logic [NUM_REQ-1:0] grant_reg, done_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [8:0]        p1_x_reg, vga_x_reg;
    logic [7:0]        p1_y_reg, vga_y_reg;
    logic [2:0]        colour_reg;
    logic [9:0]        x_sum;
    logic [8:0]        y_sum;

    // First requesting index at or after the RR pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ))
                cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!sel_found && req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign last_pix = (col_reg == w_reg - SZ_W'(1)) && (row_reg == h_reg - SZ_W'(1));

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        pix_valid  = 1'b0;
        case (state_reg)
            IDLE: if (sel_found) begin
                start      = 1'b1;
                state_next = SCAN;
            end
            SCAN: if (w_reg == '0 || h_reg == '0) begin
                state_next = DONE;
            end else begin
                pix_valid = 1'b1;
                if (last_pix) state_next = FLUSH;
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign x_sum = {1'b0, x_reg} + 10'(col_reg);
    assign y_sum = {1'b0, y_reg} + 9'(row_reg);
    // Folds to constant 1 when the colour key is disabled.
    assign show  = blackout_reg || !KEY_EN || (rom_data != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            blackout_reg <= 1'b0;
            col_reg      <= '0;
            row_reg      <= '0;
            rom_addr_reg <= '0;
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= '0;
            p1_valid_reg <= 1'b0;
            p1_clip_reg  <= 1'b0;
            p1_x_reg     <= '0;
            p1_y_reg     <= '0;
            plot_reg     <= 1'b0;
            vga_x_reg    <= '0;
            vga_y_reg    <= '0;
            colour_reg   <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= '0;
            if (start) begin
                owner_reg    <= sel_idx;
                x_reg        <= x_arr[sel_idx];
                y_reg        <= y_arr[sel_idx];
                w_reg        <= w_arr[sel_idx];
                h_reg        <= h_arr[sel_idx];
                blackout_reg <= req_blackout[sel_idx];
                rom_addr_reg <= base_arr[sel_idx];
                col_reg      <= '0;
                row_reg      <= '0;
                grant_reg    <= NUM_REQ'(1) << sel_idx;
                busy_reg     <= 1'b1;
            end
            if (pix_valid) begin
                rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
                if (col_reg == w_reg - SZ_W'(1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + SZ_W'(1);
                end else begin
                    col_reg <= col_reg + SZ_W'(1);
                end
            end
            if (state_reg == DONE) begin
                done_reg  <= grant_reg;
                grant_reg <= '0;
                busy_reg  <= 1'b0;
                ptr_reg   <= (owner_reg == PTR_W'(NUM_REQ-1)) ? '0 : owner_reg + PTR_W'(1);
            end
            // Stage 1: coordinates travel alongside the ROM read latency.
            p1_valid_reg <= pix_valid;
            p1_clip_reg  <= (x_sum > 10'(X_MAX)) || (y_sum > 9'(Y_MAX));
            p1_x_reg     <= x_sum[8:0];
            p1_y_reg     <= y_sum[7:0];
            // Stage 2: ROM data now valid for the pixel in stage 1.
            plot_reg <= p1_valid_reg && !p1_clip_reg && show;
            if (p1_valid_reg) begin
                vga_x_reg  <= p1_x_reg;
                vga_y_reg  <= p1_y_reg;
                colour_reg <= blackout_reg ? 3'b000 : rom_data;
            end
        end
    end

    assign grant      = grant_reg;
    assign done       = done_reg;
    assign busy       = busy_reg;
    assign rom_addr   = rom_addr_reg;
    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign vga_colour = colour_reg;
    assign vga_plot   = plot_reg;
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed self-checking bench for sprite_draw_scheduler (3 requesters, default sizes).
module tb_sprite_draw_scheduler;
    logic        clk, reset;
    logic [2:0]  req, req_blackout, grant, done;
    logic [26:0] req_x;
    logic [23:0] req_y;
    logic [14:0] req_w, req_h;
    logic [35:0] req_base;
    logic        busy, vga_plot;
    logic [11:0] rom_addr;
    logic [2:0]  rom_data, vga_colour;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;

    int checks = 0;
    int failures = 0;

    logic [2:0]  rom_mem [0:4095];
    logic [11:0] o_addr [32];
    logic        o_plot [32];
    logic        o_busy [32];
    logic [8:0]  o_x [32];
    logic [7:0]  o_y [32];
    logic [2:0]  o_col [32];
    logic [2:0]  o_done [32];
    logic [2:0]  o_grant [32];

    sprite_draw_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_w(req_w), .req_h(req_h), .req_base(req_base), .req_blackout(req_blackout),
        .grant(grant), .done(done), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int i, input int x, input int y, input int w, input int h,
                           input int base, input bit bo);
        req_x[9*i +: 9]       = 9'(x);
        req_y[8*i +: 8]       = 8'(y);
        req_w[5*i +: 5]       = 5'(w);
        req_h[5*i +: 5]       = 5'(h);
        req_base[12*i +: 12]  = 12'(base);
        req_blackout[i]       = bo;
    endtask

    task automatic wait_grant(input logic [2:0] exp, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 3'b000 && n < 40);
        chk("grant", grant, exp);
    endtask

    task automatic wait_done(input logic [2:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 3'b000 && n < 60);
        chk("done_owner", done, exp);
    endtask

    // Records outputs starting at the current negedge as offset 0.
    task automatic observe(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            o_addr[k] = rom_addr;  o_plot[k] = vga_plot; o_busy[k] = busy;
            o_x[k] = vga_x;        o_y[k] = vga_y;       o_col[k] = vga_colour;
            o_done[k] = done;      o_grant[k] = grant;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_plot"}, vga_plot, 0);
        chk({tag, "_vga_x"}, vga_x, 0);
        chk({tag, "_vga_y"}, vga_y, 0);
        chk({tag, "_colour"}, vga_colour, 0);
    endtask

    initial begin
        int n;
        logic [2:0] order [4];
        for (int a = 0; a < 4096; a++) rom_mem[a] = 3'd7;
        reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        req_base = '0; req_blackout = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single 2x2 job on requester 0.
        rom_mem[100] = 3'd1; rom_mem[101] = 3'd2; rom_mem[102] = 3'd3; rom_mem[103] = 3'd4;
        set_job(0, 10, 20, 2, 2, 100, 1'b0);
        req = 3'b001;
        wait_grant(3'b001, n);
        req = 3'b000;
        observe(8);
        for (int p = 0; p < 4; p++) begin
            chk("t1_addr", o_addr[p], 100 + p);
            chk("t1_plot", o_plot[p+2], 1);
            chk("t1_x", o_x[p+2], 10 + (p % 2));
            chk("t1_y", o_y[p+2], 20 + (p / 2));
            chk("t1_colour", o_col[p+2], p + 1);
        end
        chk("t1_plot_before", o_plot[1], 0);
        chk("t1_plot_after", o_plot[6], 0);
        chk("t1_done_early", o_done[5], 0);
        chk("t1_done", o_done[6], 3'b001);
        chk("t1_done_once", o_done[7], 0);
        chk("t1_busy_held", o_busy[5], 1);
        chk("t1_busy_fall", o_busy[6], 0);
        chk("t1_grant_fall", o_grant[6], 0);

        // Right-edge clipping on requester 1 (pointer now at 1).
        set_job(1, 318, 0, 4, 1, 200, 1'b0);
        req = 3'b010;
        wait_grant(3'b010, n);
        req = 3'b000;
        observe(8);
        chk("t3_plot318", o_plot[2], 1);
        chk("t3_x318", o_x[2], 318);
        chk("t3_plot319", o_plot[3], 1);
        chk("t3_x319", o_x[3], 319);
        chk("t3_clip320", o_plot[4], 0);
        chk("t3_clip321", o_plot[5], 0);
        chk("t3_done_early", o_done[5], 0);
        chk("t3_done", o_done[6], 3'b010);

        // Blackout on requester 2 with non-zero ROM content.
        for (int a = 300; a < 303; a++) rom_mem[a] = 3'b101;
        set_job(2, 50, 60, 3, 1, 300, 1'b1);
        req = 3'b100;
        wait_grant(3'b100, n);
        req = 3'b000;
        observe(7);
        for (int p = 0; p < 3; p++) begin
            chk("t4_plot", o_plot[p+2], 1);
            chk("t4_colour", o_col[p+2], 0);
            chk("t4_x", o_x[p+2], 50 + p);
        end
        chk("t4_done", o_done[5], 3'b100);

        // Colour-key pattern 000,110,000 on requester 0.
        rom_mem[400] = 3'b000; rom_mem[401] = 3'b110; rom_mem[402] = 3'b000;
        set_job(0, 5, 6, 3, 1, 400, 1'b0);
        req = 3'b001;
        wait_grant(3'b001, n);
        req = 3'b000;
        observe(7);
`ifdef DRAW_SCHED_TRANSPARENCY_EN
        chk("t6_plot0", o_plot[2], 0);
        chk("t6_plot1", o_plot[3], 1);
        chk("t6_colour1", o_col[3], 3'b110);
        chk("t6_plot2", o_plot[4], 0);
`else
        chk("t6_plot0", o_plot[2], 1);
        chk("t6_colour0", o_col[2], 3'b000);
        chk("t6_plot1", o_plot[3], 1);
        chk("t6_colour1", o_col[3], 3'b110);
        chk("t6_plot2", o_plot[4], 1);
        chk("t6_colour2", o_col[4], 3'b000);
`endif
        chk("t6_done", o_done[5], 3'b001);

        // Zero-width job on requester 1.
        set_job(1, 7, 7, 0, 3, 500, 1'b0);
        req = 3'b010;
        wait_grant(3'b010, n);
        req = 3'b000;
        observe(5);
        chk("t6w0_done_early", o_done[1], 0);
        chk("t6w0_done", o_done[2], 3'b010);
        for (int k = 0; k < 5; k++) chk("t6w0_noplot", o_plot[k], 0);

        // Mid-job reset on a 4x4 job from requester 2.
        set_job(2, 100, 100, 4, 4, 600, 1'b0);
        req = 3'b100;
        wait_grant(3'b100, n);
        req = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t5_reset");
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t5_no_done", done, 0);
        end
        set_job(0, 1, 1, 1, 1, 10, 1'b0);
        set_job(2, 2, 2, 1, 1, 20, 1'b0);
        req = 3'b101;
        wait_grant(3'b001, n);
        req = 3'b000;
        wait_done(3'b001);

        // Round-robin with all three requesters held high from reset.
        reset = 1'b1;
        set_job(0, 30, 30, 1, 1, 0, 1'b0);
        set_job(1, 31, 30, 1, 1, 1, 1'b0);
        set_job(2, 32, 30, 1, 1, 2, 1'b0);
        req = 3'b111;
        @(negedge clk);
        reset = 1'b0;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        for (int j = 0; j < 4; j++) begin
            wait_grant(order[j], n);
            if (j > 0) chk("t2_gap", n, 1);
            if (j == 3) req = 3'b100;
            wait_done(order[j]);
        end
        for (int j = 0; j < 2; j++) begin
            wait_grant(3'b100, n);
            chk("t2_req2_gap", n, 1);
            if (j == 1) req = 3'b000;
            wait_done(3'b100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
